// File: rtl/inverse_cipher.sv
// Fully pipelined AES-128 inverse cipher: one ciphertext block per clock, 11-cycle latency.
// Round keys are expanded combinationally from the cipher key; S-boxes are computed in GF(2^8).
module inverse_cipher #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:127] key,
  input  logic [0:127] in,
  input  logic         valid_in,
  output logic [0:127] out,
  output logic         valid_out
);

  localparam int unsigned Words = 4 * (Nr + 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // x^254 by square-and-multiply; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Byte j of a 128-bit state lives at [127-8j -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [7:0]   b [16];
    logic [31:0]  col;
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        b[rw + 4*c] = inv_sbox(s[127 - 8*(rw + 4*((c + 4 - rw) % 4)) -: 8])
                      ^ k[127 - 8*(rw + 4*c) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      col = {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]};
      r[127 - 32*c -: 32] = mix ? inv_mix_col(col) : col;
    end
    return r;
  endfunction

  logic [127:0] rk      [Nr+1];
  logic [127:0] stage_q [Nr+1];
  logic [Nr:0]  valid_q;
  logic [127:0] in_w;

  assign in_w = in;

  always_comb begin : key_expand
    logic [31:0] w [Words];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc  = 8'h01;
    tmp = '0;
    for (int i = 0; i < Words; i++) begin
      if (i < Nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        tmp = w[i-1];
        if (i % Nk == 0) begin
          tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
          rc  = xtime(rc);
        end
        w[i] = w[i-Nk] ^ tmp;
      end
    end
    for (int r = 0; r <= Nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

  // Data stages load every cycle; validity rides alongside in valid_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= Nr; k++) stage_q[k] <= '0;
      valid_q <= '0;
    end else begin
      stage_q[0] <= in_w ^ rk[Nr];
      for (int k = 1; k <= Nr; k++) stage_q[k] <= inv_round(stage_q[k-1], rk[Nr-k], k != Nr);
      valid_q <= {valid_q[Nr-1:0], valid_in};
    end
  end

  assign out       = stage_q[Nr];
  assign valid_out = valid_q[Nr];

endmodule

// File: tb/tb_inverse_cipher.sv
// Bench for inverse_cipher: plaintexts are encrypted by a forward AES model, fed as ciphertext,
// and the DUT output is checked every cycle against a timeline of expected (valid, plaintext).
module tb_inverse_cipher;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] key;
  logic [127:0] din;
  logic         valid_in;
  logic [127:0] dout;
  logic         valid_out;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic         exp_v [16];
  logic [127:0] exp_d [16];
  logic [7:0]   sbox_t [256];

  inverse_cipher #(.Nk(4), .Nr(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .in       (din),
    .valid_in (valid_in),
    .out      (dout),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h want %h", tag, edge_cnt, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  // Forward S-box: brute-force multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   rk [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, b0, a0, a1, a2, a3;
    logic [127:0] res;
    for (int j = 0; j < 16; j++) begin
      rk[j] = k[127-8*j -: 8];
      s[j]  = p[127-8*j -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = rk[4*(i-1)+j];
      if (i % 4 == 0) begin
        b0     = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[b0];
        rc     = xt(rc);
      end
      for (int j = 0; j < 4; j++) rk[4*i+j] = rk[4*(i-4)+j] ^ tmp[j];
    end
    for (int j = 0; j < 16; j++) s[j] = s[j] ^ rk[j];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[rw+4*c] = sbox_t[s[rw + 4*((c+rw)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ rk[16*r+j];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  // One cycle: check what the previous edge produced, then drive the next input.
  task automatic step(input logic v, input logic [127:0] ct, input logic [127:0] pt);
    int slot;
    @(negedge clk);
    slot = edge_cnt % 16;
    check("valid_out", {127'd0, valid_out}, {127'd0, exp_v[slot]});
    if (exp_v[slot]) check("plaintext", dout, exp_d[slot]);
    valid_in = v;
    din      = ct;
    exp_v[(edge_cnt + 11) % 16] = v & rst_n;
    exp_d[(edge_cnt + 11) % 16] = pt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 128'd0, 128'd0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called right after a step: asserts reset between edges, then releases it at a falling edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", dout, 128'd0);
    check("rst_valid", {127'd0, valid_out}, 128'd0);
    for (int i = 0; i < 16; i++) exp_v[i] = 1'b0;
    step(1'b1, rnd128(), 128'd0);
    step(1'b1, rnd128(), 128'd0);
    step(1'b0, 128'd0, 128'd0);
    rst_n = 1'b1;
  endtask

  logic [127:0] ct [3];
  logic [127:0] pt [3];
  logic [127:0] p;
  logic         v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    valid_in = 1'b0;
    din      = '0;
    key      = '0;
    for (int i = 0; i < 16; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = '0;
    end
    build_sbox();
    ct[0] = 128'h0a940bb5416ef045f1c39458c653ea5a;
    ct[1] = 128'h20a9f992b44c5be8041ffcdc6cae996a;
    ct[2] = 128'hb7ea90af536c82a8c8df97106b978f5a;
    pt[0] = 128'h000102030405060708090a0b0c0d0e0f;
    pt[1] = 128'h0f0e0d0c0b0a09080706050403020100;
    pt[2] = 128'h00000101030307070f0f1f1f3f3f7f7f;

    #1 rst_n = 1'b0;
    #1;
    check("init_out", dout, 128'd0);
    check("init_valid", {127'd0, valid_out}, 128'd0);
    idle(2);
    rst_n = 1'b1;

    // Known answer, single block.
    key = 128'h000102030405060708090a0b0c0d0e0f;
    step(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
    idle(12);

    // Back-to-back.
    for (int i = 0; i < 3; i++) step(1'b1, ct[i], pt[i]);
    idle(12);

    // Three blocks in flight, then reset: none may emerge.
    for (int i = 0; i < 3; i++) step(1'b1, ct[i], pt[i]);
    idle(2);
    async_reset();
    idle(14);

    // Reversed order after reset.
    for (int i = 2; i >= 0; i--) step(1'b1, ct[i], pt[i]);
    idle(12);

    // Valid pattern 1,0,1.
    step(1'b1, ct[0], pt[0]);
    step(1'b0, ct[1], pt[1]);
    step(1'b1, ct[2], pt[2]);
    idle(12);

    // Random batches, each under its own key, valid held high.
    for (int b = 0; b < 4; b++) begin
      key = rnd128();
      for (int i = 0; i < 250; i++) begin
        p = rnd128();
        step(1'b1, aes_enc(key, p), p);
      end
      idle(12);
    end

    // Random valid gaps.
    key = rnd128();
    for (int i = 0; i < 200; i++) begin
      p = rnd128();
      v = 1'($urandom_range(0, 1));
      step(v, aes_enc(key, p), p);
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inverse_cipher.md
Name: inverse_cipher

Overview:
- Fully pipelined AES-128 decryption core (FIPS-197 inverse cipher); accepts one 128-bit ciphertext block per clock and emits the plaintext after a fixed latency.
- Sits in the decrypt datapath beside the forward cipher core and shares its byte-ordering conventions.
- Round keys are expanded internally from a single cipher key port.

Parameters:
- Nk, 4, key length in 32-bit words; only 4 (AES-128) is supported.
- Nr, 10, number of rounds; only 10 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- key  input  128 [0:127]  cipher key; bits [0:7] are key byte 0 (FIPS byte order, MSB-first). Must stay stable while any block is in flight.
- in  input  128 [0:127]  ciphertext block, same byte order.
- valid_in  input  1  qualifies `in` on the current rising edge.
- out  output  128 [0:127]  plaintext block, same byte order.
- valid_out  output  1  qualifies `out`.

Behaviour:
- Data model:
  - State bytes map column-major per FIPS: byte 4c+r is row r, column c.
  - The round keys w[0..43] are computed combinationally from `key` using the standard expansion (SubWord, RotWord, Rcon 01,02,04,08,10,20,40,80,1b,36).
- Pipeline: 11 register stages, S0..S10.
  - S0 <= in XOR roundkey[10].
  - Stage k, for k = 1..9: Sk <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(Sk-1)), roundkey[10-k])).
  - S10 <= AddRoundKey(InvSubBytes(InvShiftRows(S9)), roundkey[0]).
  - out = S10 (registered output).
- Latency:
  - A block sampled on rising edge N appears on `out` with valid_out = 1 after edge N+10, i.e. 11 edges after sampling counting edge N.
  - Throughput is 1 block per cycle, with no stalls and no backpressure.
- Valid handling:
  - An 11-bit valid shift register travels alongside the data.
  - The data stages load every cycle regardless of valid_in.
  - valid_out is the last bit of the valid shift register.
  - Consumers must qualify `out` with valid_out.
- Back-to-back blocks: consecutive valid inputs produce consecutive valid outputs in the same order, with no bubbles.
- valid_in low for a cycle produces a single valid_out = 0 bubble exactly 11 cycles later; `out` is don't-care in that cycle.
- Reset:
  - While rst_n = 0, all stage registers, `out`, and every valid bit are asynchronously cleared to 0.
  - Reset mid-operation flushes all in-flight blocks; none of them is ever emitted.
  - After release, the first valid output comes from the first input sampled with valid_in = 1 and rst_n = 1.
- Key changes:
  - Changing `key` while blocks are in flight is unsupported; those outputs are undefined.
  - Blocks sampled after the key has been stable for the whole pipeline depth decrypt correctly.
- Arithmetic:
  - InvMixColumns uses GF(2^8) with polynomial 0x11b and coefficients 0e, 0b, 0d, 09.
  - InvSubBytes uses the FIPS inverse S-box. It may be implemented as a table or arithmetically; the result must be bit-exact.
- Input values: no invalid states exist; all 2^128 inputs are legal.

Test Plan:
- Known-answer test, key 000102030405060708090a0b0c0d0e0f, in = 69c4e0d86a7b0430d8cdb78070b4c55a -> out = 00112233445566778899aabbccddeeff with valid_out = 1 exactly 11 edges after sampling.
- Same key, back-to-back inputs 0a940bb5416ef045f1c39458c653ea5a, 20a9f992b44c5be8041ffcdc6cae996a, b7ea90af536c82a8c8df97106b978f5a on consecutive cycles -> outputs on three consecutive cycles:
  - 000102030405060708090a0b0c0d0e0f
  - 0f0e0d0c0b0a09080706050403020100
  - 00000101030307070f0f1f1f3f3f7f7f
- Reverse the input order of the three ciphertexts above after a reset -> plaintexts appear in the reversed order, and no stale pre-reset data is ever flagged valid.
- Reset asserted asynchronously (between clock edges) while 3 blocks are in flight -> out = 0 and valid_out = 0 immediately. After release, valid_out stays 0 until 11 edges after the next valid input.
- valid_in pattern 1,0,1 -> valid_out pattern 1,0,1 starting 11 edges later. The two valid outputs are the correct plaintexts.
- 1000 random blocks under random keys (key held stable per batch), compared against a reference AES model -> all outputs match, with zero valid_out gaps when valid_in is held at 1.
